// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: per-frame configurable UART transmitter with one-entry holding register; UART_TX_BREAK_EN adds a break generator
module uart_tx_cfg #(
  parameter int MAX_WIDTH  = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [MAX_WIDTH-1:0]  P_Data,
  input  logic                  Data_Valid,
  output logic                  Data_Ready,
  input  logic [3:0]            Data_Len,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESCALE_W-1:0] Baud_Div,
`ifdef UART_TX_BREAK_EN
  input  logic                  Send_Break,
`endif
  output logic                  TX_Out,
  output logic                  Busy,
  output logic                  Frame_Done
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP1, ST_STOP2
`ifdef UART_TX_BREAK_EN
    , ST_BREAK
`endif
  } state_t;
  localparam logic [3:0] MW = 4'(MAX_WIDTH);
  state_t                state, state_n;
  logic [PRESCALE_W-1:0] cnt, cnt_n, cur_div, hold_div;
  logic [3:0]            bit_idx, bit_n, eff_len, cur_len, hold_len;
  logic [MAX_WIDTH-1:0]  sh, sh_n, masked, hold_data;
  logic                  hold_full, hold_par_en, hold_par, hold_stop2;
  logic                  cur_par_en, cur_par, cur_stop2;
  logic                  xfer, load, eof, tick, tx_n, done_n, brk;
  assign Data_Ready = !hold_full && !brk;
  assign xfer       = Data_Valid && Data_Ready;
  assign Busy       = (state != ST_IDLE) || hold_full;
  assign tick       = cnt == cur_div;
  // Clamp the requested length and drop data bits beyond it
  always_comb begin
    eff_len = (Data_Len < 4'd5 || Data_Len > MW) ? MW : Data_Len;
    masked  = '0;
    for (int i = 0; i < MAX_WIDTH; i++) masked[i] = (4'(i) < eff_len) & P_Data[i];
  end
  // Holding register: captures data and frame config together, parity precomputed
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      hold_full   <= 1'b0;
      hold_data   <= '0;
      hold_len    <= MW;
      hold_par_en <= 1'b0;
      hold_par    <= 1'b0;
      hold_stop2  <= 1'b0;
      hold_div    <= '0;
    end else if (xfer) begin
      hold_full   <= 1'b1;
      hold_data   <= masked;
      hold_len    <= eff_len;
      hold_par_en <= PAR_EN;
      hold_par    <= ^masked ^ PAR_TYP;
      hold_stop2  <= STOP2;
      hold_div    <= Baud_Div;
    end else if (load) hold_full <= 1'b0;
  // Next-state, baud/bit counters, shifter and registered line value
  always_comb begin
    state_n = state;
    cnt_n   = tick ? '0 : cnt + PRESCALE_W'(1);
    bit_n   = bit_idx;
    sh_n    = sh;
    load    = 1'b0;
    eof     = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (hold_full) begin
          state_n = ST_START;
          load    = 1'b1;
        end
`ifdef UART_TX_BREAK_EN
        else if (Send_Break) state_n = ST_BREAK;
`endif
      end
      ST_START: if (tick) begin
        state_n = ST_DATA;
        bit_n   = '0;
      end
      ST_DATA: if (tick) begin
        sh_n  = sh >> 1;
        bit_n = bit_idx + 4'd1;
        if (bit_idx == cur_len - 4'd1) state_n = cur_par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: if (tick) state_n = ST_STOP1;
      ST_STOP1: if (tick) begin
        if (cur_stop2) state_n = ST_STOP2;
        else eof = 1'b1;
      end
      ST_STOP2: eof = tick;
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        cnt_n = '0;
        if (!Send_Break) state_n = ST_STOP1;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
    if (eof) begin
      done_n  = !brk;
      state_n = hold_full ? ST_START : ST_IDLE;
      load    = hold_full;
    end
    if (load) sh_n = hold_data;
    tx_n = (state_n == ST_START) ? 1'b0 : (state_n == ST_DATA) ? sh_n[0] :
           (state_n == ST_PARITY) ? cur_par : 1'b1;
`ifdef UART_TX_BREAK_EN
    if (state_n == ST_BREAK) tx_n = 1'b0;
`endif
  end
  // State, counters, shifter, active frame config and registered outputs
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      sh         <= '0;
      cur_len    <= MW;
      cur_par_en <= 1'b0;
      cur_par    <= 1'b0;
      cur_stop2  <= 1'b0;
      cur_div    <= '0;
      TX_Out     <= 1'b1;
      Frame_Done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      sh         <= sh_n;
      TX_Out     <= tx_n;
      Frame_Done <= done_n;
      if (load) begin
        cur_len    <= hold_len;
        cur_par_en <= hold_par_en;
        cur_par    <= hold_par;
        cur_stop2  <= hold_stop2;
        cur_div    <= hold_div;
      end
`ifdef UART_TX_BREAK_EN
      else if (state == ST_IDLE && state_n == ST_BREAK) begin
        cur_stop2 <= 1'b0;
        cur_div   <= hold_div;
      end
`endif
    end
`ifdef UART_TX_BREAK_EN
  // Break sequence flag: covers BREAK and its trailing stop bit
  always_ff @(posedge CLK or posedge RST)
    if (RST) brk <= 1'b0;
    else brk <= (state_n == ST_BREAK) || (brk && state_n != ST_IDLE);
`else
  assign brk = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench for uart_tx_cfg
module tb_uart_tx_cfg;
  typedef struct {
    logic [15:0] bits;
    int          n;
    int          div;
  } frame_t;
  logic        CLK = 0, RST = 0, Data_Valid = 0, PAR_EN = 0, PAR_TYP = 0, STOP2 = 0;
  logic [7:0]  P_Data = '0;
  logic [3:0]  Data_Len = 4'd8;
  logic [15:0] Baud_Div = '0;
  logic        Data_Ready, TX_Out, Busy, Frame_Done;
`ifdef UART_TX_BREAK_EN
  logic        Send_Break = 0;
`endif
  frame_t sb[$];
  int total = 0, bad = 0;
  bit mon_en = 1, in_frame = 0, pending_done = 0;
  uart_tx_cfg #(.MAX_WIDTH(8), .PRESCALE_W(16)) dut (
    .CLK(CLK), .RST(RST), .P_Data(P_Data), .Data_Valid(Data_Valid), .Data_Ready(Data_Ready),
    .Data_Len(Data_Len), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .Baud_Div(Baud_Div),
`ifdef UART_TX_BREAK_EN
    .Send_Break(Send_Break),
`endif
    .TX_Out(TX_Out), .Busy(Busy), .Frame_Done(Frame_Done)
  );
  always #5 CLK = ~CLK;
  function automatic frame_t build(input logic [7:0] d, input int len, input logic pe, pt, s2, input int div);
    frame_t f;
    int eff;
    logic p;
    eff = (len < 5 || len > 8) ? 8 : len;
    p = pt;
    f.bits = '0;
    f.div = div;
    f.n = 1;
    for (int i = 0; i < eff; i++) begin
      f.bits[f.n] = d[i];
      p ^= d[i];
      f.n++;
    end
    if (pe) begin
      f.bits[f.n] = p;
      f.n++;
    end
    f.bits[f.n] = 1'b1;
    f.n++;
    if (s2) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    return f;
  endfunction
  // Serial monitor: pops the expected frame on each start bit and checks every cycle of it
  initial begin : mon
    frame_t f;
    bit abort;
    forever begin
      @(negedge CLK);
      if (pending_done) begin
        total++;
        if (Frame_Done !== 1'b1) begin
          bad++;
          $display("FAIL frame_done_pulse: got %b want 1", Frame_Done);
        end
        pending_done = 0;
      end
      if (mon_en && !RST && TX_Out === 1'b0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_start: TX_Out=0 with no frame queued at %0t", $time);
        end else begin
          f = sb.pop_front();
          in_frame = 1;
          abort = 0;
          for (int i = 0; i < f.n && !abort; i++)
            for (int c = 0; c <= f.div && !abort; c++) begin
              if (i != 0 || c != 0) begin
                @(negedge CLK);
                if (RST) abort = 1;
              end
              if (!abort) begin
                total++;
                if (TX_Out !== f.bits[i]) begin
                  bad++;
                  $display("FAIL line_bit%0d_cyc%0d: got %b want %b", i, c, TX_Out, f.bits[i]);
                end
                if (i != 0 || c != 0) begin
                  total++;
                  if (Frame_Done !== 1'b0) begin
                    bad++;
                    $display("FAIL frame_done_early: got %b want 0 at bit %0d", Frame_Done, i);
                  end
                end
              end
            end
          pending_done = !abort;
          in_frame = 0;
        end
      end
    end
  end
  task automatic send(input logic [7:0] d, input int len, input logic pe, pt, s2, input int div);
    int w = 0;
    while (Data_Ready !== 1'b1 && w < 500) begin
      @(posedge CLK);
      #1;
      w++;
    end
    total++;
    if (Data_Ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready_timeout: Data_Ready=%b want 1", Data_Ready);
    end
    P_Data = d;
    Data_Len = 4'(len);
    PAR_EN = pe;
    PAR_TYP = pt;
    STOP2 = s2;
    Baud_Div = 16'(div);
    Data_Valid = 1;
    sb.push_back(build(d, len, pe, pt, s2, div));
    @(posedge CLK);
    #1;
    Data_Valid = 0;
  endtask
  task automatic wait_idle;
    int w = 0;
    do begin
      @(posedge CLK);
      #1;
      w++;
    end while ((Busy !== 1'b0 || sb.size() != 0 || in_frame || pending_done) && w < 2000);
    total++;
    if (w >= 2000) begin
      bad++;
      $display("FAIL idle_timeout: Busy=%b queued=%0d", Busy, sb.size());
    end
  endtask
  task automatic test_reset;
    RST = 1;
    repeat (2) @(posedge CLK);
    #1;
    total += 4;
    if (TX_Out !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", TX_Out); end
    if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    if (Data_Ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", Data_Ready); end
    if (Frame_Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Frame_Done); end
    RST = 0;
    repeat (2) @(posedge CLK);
    #1;
  endtask
  task automatic test_8n1;
    int c = 0;
    send(8'hA5, 8, 0, 0, 0, 3);
    total += 2;
    if (TX_Out !== 1'b1) begin bad++; $display("FAIL latency_pre: got %b want 1", TX_Out); end
    if (Data_Ready !== 1'b0) begin bad++; $display("FAIL ready_load_cycle: got %b want 0", Data_Ready); end
    @(posedge CLK);
    #1;
    total += 2;
    if (TX_Out !== 1'b0) begin bad++; $display("FAIL latency_start: got %b want 0", TX_Out); end
    if (Data_Ready !== 1'b1) begin bad++; $display("FAIL ready_after_load: got %b want 1", Data_Ready); end
    while (Frame_Done !== 1'b1 && c < 200) begin
      @(posedge CLK);
      #1;
      c++;
    end
    total++;
    if (c != 40) begin bad++; $display("FAIL done_timing: got %0d cycles want 40", c); end
    @(posedge CLK);
    #1;
    total += 2;
    if (Busy !== 1'b0) begin bad++; $display("FAIL busy_after_frame: got %b want 0", Busy); end
    if (Frame_Done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", Frame_Done); end
    wait_idle();
  endtask
  task automatic test_parity;
    send(8'h83, 7, 1, 1, 0, 1);
    wait_idle();
    send(8'h5A, 3, 1, 0, 1, 1);
    wait_idle();
  endtask
  task automatic test_back_to_back;
    int p[$];
    send(8'h55, 8, 0, 0, 1, 0);
    send(8'h0F, 8, 0, 0, 1, 0);
    total++;
    if (in_frame !== 1'b1) begin bad++; $display("FAIL b2b_accept_during_frame: in_frame=%b want 1", in_frame); end
    for (int c = 0; c < 80; c++) begin
      @(posedge CLK);
      #1;
      if (Frame_Done === 1'b1) p.push_back(c);
    end
    total++;
    if (p.size() != 2) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d want 2", p.size());
    end else begin
      total++;
      if (p[1] - p[0] != 11) begin bad++; $display("FAIL b2b_done_gap: got %0d want 11", p[1] - p[0]); end
    end
    wait_idle();
  endtask
  task automatic test_clamp_isolation;
    send(8'h3C, 12, 0, 0, 0, 3);
    repeat (10) @(posedge CLK);
    #1;
    Baud_Div = 16'd1;
    P_Data = 8'hFF;
    Data_Len = 4'd5;
    STOP2 = 1;
    wait_idle();
    send(8'h96, 8, 0, 0, 0, 1);
    wait_idle();
  endtask
  task automatic test_reset_mid;
    send(8'h12, 8, 0, 0, 0, 3);
    send(8'hE7, 8, 1, 0, 0, 3);
    repeat (8) @(posedge CLK);
    #1;
    RST = 1;
    sb.delete();
    #1;
    total += 3;
    if (TX_Out !== 1'b1) begin bad++; $display("FAIL rst_mid_tx: got %b want 1", TX_Out); end
    if (Data_Ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", Data_Ready); end
    if (Busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", Busy); end
    repeat (3) @(posedge CLK);
    #1;
    RST = 0;
    begin
      int lows = 0;
      for (int c = 0; c < 80; c++) begin
        @(posedge CLK);
        #1;
        if (TX_Out !== 1'b1 || Busy !== 1'b0) lows++;
      end
      total++;
      if (lows != 0) begin bad++; $display("FAIL rst_mid_quiet: got %0d active cycles want 0", lows); end
    end
  endtask
`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    int lo = 0, hi = 0, dr = 0, fd = 0;
    send(8'h11, 8, 0, 0, 0, 3);
    wait_idle();
    mon_en = 0;
    Send_Break = 1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 20; i++) begin
      if (TX_Out === 1'b0) lo++;
      if (Data_Ready !== 1'b0) dr++;
      if (Frame_Done !== 1'b0) fd++;
      if (i < 19) begin
        @(posedge CLK);
        #1;
      end
    end
    Send_Break = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      if (TX_Out === 1'b1) hi++;
      if (Data_Ready !== 1'b0) dr++;
      if (Frame_Done !== 1'b0) fd++;
    end
    @(posedge CLK);
    #1;
    total += 6;
    if (lo != 20) begin bad++; $display("FAIL break_low: got %0d want 20", lo); end
    if (hi != 4) begin bad++; $display("FAIL break_stop: got %0d want 4", hi); end
    if (dr != 0) begin bad++; $display("FAIL break_ready: got %0d ready cycles want 0", dr); end
    if (fd != 0) begin bad++; $display("FAIL break_done: got %0d pulses want 0", fd); end
    if (Busy !== 1'b0) begin bad++; $display("FAIL break_idle_busy: got %b want 0", Busy); end
    if (Data_Ready !== 1'b1) begin bad++; $display("FAIL break_idle_ready: got %b want 1", Data_Ready); end
    mon_en = 1;
  endtask
`endif
  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_clamp_isolation();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
